// File: rtl/cdb_pkg.sv
// Shared types and default sizing for the common data bus arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package cdb_pkg;

  localparam int CDB_N_REQ        = 4;
  localparam int CDB_TAG_W        = 6;
  localparam int CDB_DATA_W       = 32;
  localparam int CDB_STARVE_LIMIT = 8;

  // Execution units in requester-index order
  typedef enum logic [1:0] {
    UNIT_INT  = 2'd0,
    UNIT_MUL  = 2'd1,
    UNIT_DIV  = 2'd2,
    UNIT_LDST = 2'd3
  } unit_e;

  // One result broadcast on the bus
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_packet_t;

  // Index width that stays legal for a single requester
  function automatic int cdb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first requesting index at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick becomes a grant.
module rr_picker
  import cdb_pkg::*;
#(
  parameter int N     = CDB_N_REQ,
  parameter int IDX_W = cdb_idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick
);

  logic found;
  int   idx;

  // Walk upward from ptr and take the first requester found
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates execution-unit results onto one broadcast bus: round-robin with a starvation override.
// Latency: grant is combinational; the granted packet appears on cdb_* exactly one cycle later.
// Backpressure: requesters hold valid/tag/data until granted; flush suppresses every grant for that cycle.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int N_REQ        = CDB_N_REQ,
  parameter  int TAG_W        = CDB_TAG_W,
  parameter  int DATA_W       = CDB_DATA_W,
  parameter  int STARVE_LIMIT = CDB_STARVE_LIMIT,
  localparam int SRC_W        = cdb_idx_w(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0][TAG_W-1:0]    req_tag,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]               grant,
  output logic                           cdb_valid,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [DATA_W-1:0]              cdb_data,
  output logic [SRC_W-1:0]               cdb_src
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [SRC_W-1:0]  ptr;
  logic [CNT_W-1:0]  wait_cnt [N_REQ];
  logic [N_REQ-1:0]  rr_pick;
  logic [N_REQ-1:0]  starving;
  logic [N_REQ-1:0]  starve_pick;
  logic [SRC_W-1:0]  grant_idx;
  logic              grant_any;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_rr_picker (
    .req  (req_valid),
    .ptr  (ptr),
    .pick (rr_pick)
  );

  // A requester is starving once it has waited the full limit while still valid
  always_comb begin
    starving = '0;
    for (int i = 0; i < N_REQ; i++) begin
      starving[i] = req_valid[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Isolate the lowest starving index
  always_comb begin
    starve_pick = starving & (~starving + N_REQ'(1));
  end

  // Final grant: starvation beats round-robin; reset and flush force zero
  always_comb begin
    grant = '0;
    if (rst && !flush) begin
      grant = (|starving) ? starve_pick : rr_pick;
    end
  end

  // Encode the one-hot grant and steer the winning payload
  always_comb begin
    grant_idx = '0;
    sel_tag   = '0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = SRC_W'(i);
        sel_tag   = req_tag[i];
        sel_data  = req_data[i];
      end
    end
  end

  assign grant_any = |grant;

  // Pointer moves just past the winner; holds on idle or flush cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  // Wait counters: count ungranted valid cycles, saturate, clear on grant, idle or flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (flush || !req_valid[i] || grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Broadcast register: valid pulses per grant, payload holds between grants
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_tag  <= sel_tag;
        cdb_data <= sel_data;
        cdb_src  <= grant_idx;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of execution-unit requesters (0=INT, 1=MUL, 2=DIV, 3=LDST).
REQ-002 Parameter TAG_W, default 6: ROB tag width.
REQ-003 Parameter DATA_W, default 32: result data width.
REQ-004 Parameter STARVE_LIMIT, default 8: wait cycles after which a requester is forced to win.
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 flush  input  1  pipeline flush (mispredict); synchronous.
REQ-009 req_valid  input  N_REQ  per-unit result ready to broadcast.
REQ-010 req_tag  input  N_REQ x TAG_W  per-unit ROB tag.
REQ-011 req_data  input  N_REQ x DATA_W  per-unit result.
REQ-012 grant  output  N_REQ  one-hot combinational grant; transfer = req_valid[i] & grant[i].
REQ-013 cdb_valid  output  1  registered broadcast valid.
REQ-014 cdb_tag  output  TAG_W  registered broadcast tag.
REQ-015 cdb_data  output  DATA_W  registered broadcast data.
REQ-016 cdb_src  output  clog2(N_REQ)  index of unit that won the broadcast.

Function
REQ-017 grant SHALL be zero or one-hot, never asserted to a requester with req_valid=0.
REQ-018 Requesters SHALL hold valid/tag/data stable until granted; arbiter relies on this, no internal request latching.
REQ-019 Without starvation, winner SHALL be the first requesting index at or after round-robin pointer ptr, searching upward with wrap N_REQ-1 -> 0.
REQ-020 After a grant to index i, ptr SHALL become (i+1) mod N_REQ; with no grant, ptr SHALL hold.
REQ-021 Per-requester wait_cnt[i] SHALL increment (saturating at STARVE_LIMIT) each cycle req_valid[i]=1 and grant[i]=0, and clear on grant or when req_valid[i]=0.
REQ-022 If any wait_cnt equals STARVE_LIMIT, the lowest such index SHALL be granted, overriding round-robin; ptr update per REQ-020 still applies.
REQ-023 Latency: granted packet SHALL appear on cdb_* exactly one cycle after the grant cycle, cdb_valid=1 for exactly one cycle per grant.
REQ-024 Cycle with no grant SHALL produce cdb_valid=0 next cycle; cdb_tag/cdb_data/cdb_src hold previous values.
REQ-025 flush=1 SHALL force grant=0 that cycle, cdb_valid=0 the next cycle, clear all wait_cnt, and hold ptr.
REQ-026 Throughput: one broadcast per cycle sustained while any requester is valid and flush=0.
REQ-027 Single requester SHALL be granted the same cycle it asserts req_valid regardless of ptr.

Reset
REQ-028 On rst=0, asynchronously: ptr=0, all wait_cnt=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0; grant=0 while rst=0.
REQ-029 Reset asserted mid-broadcast SHALL drop cdb_valid immediately; first grant possible on first clk edge after release.

Structure
REQ-030 cdb_pkg SHALL hold cdb_packet_t (tag, data), unit index enum (INT, MUL, DIV, LDST), and default TAG_W/DATA_W/N_REQ constants.
REQ-031 Round-robin search SHALL be one sub-module rr_picker (inputs req, ptr; output one-hot pick), instanced once.
REQ-032 Starvation counters and output register SHALL reside in cdb_arbiter.

Verification
REQ-033 Reset release, req_valid=4'b1111 held -> grants 0,1,2,3,0 on consecutive cycles; cdb_src 0,1,2,3,0 one cycle later.
REQ-034 ptr=3 (after grant to 2), req_valid=4'b0001 -> grant=4'b0001 same cycle (wrap), cdb_tag=req_tag[0] next cycle, ptr=1.
REQ-035 req_valid[2] held while forcing REQ-019 to pick others for 8 cycles (e.g. sequencing req 0/1/3 pattern) -> wait_cnt[2]=8, grant[2]=1 next cycle despite ptr.
REQ-036 Grant to MUL with tag 6'h15, data 32'hDEADBEEF, flush=1 the following cycle with req_valid=4'b1111 -> cdb_valid=1 (tag 6'h15) then cdb_valid=0, grant=0 in flush cycle, ptr unchanged.
REQ-037 Assert rst=0 between clk edges while cdb_valid=1 -> cdb_valid=0 immediately, all outputs zero, ptr=0 after release.
REQ-038 Random valids with stable hold for 10k cycles -> grant one-hot/zero always, every request granted within N_REQ+STARVE_LIMIT cycles, no tag lost or duplicated on CDB.
